// File: rtl/trng_csr_bank.sv
// TRNG CSR bank: per-channel LFSR seed/poly/sample registers plus a measurement-window sequencer.
// Latency: register reads return on rdata_o one cycle after the access; writes take effect on the access edge.
// Backpressure: none; the bus port accepts one access every cycle, and a START while busy is flagged as OVERRUN.
module trng_csr_bank #(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_CH     = 4,
    parameter int LFSR_WIDTH = 12,
    parameter int TMW_WIDTH  = 12,
    parameter logic [TMW_WIDTH-1:0]  TMW_DEFAULT  = TMW_WIDTH'(100),
    parameter logic [LFSR_WIDTH-1:0] POLY_DEFAULT = LFSR_WIDTH'('h829)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic [3:0]                   we_i,
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    input  logic [31:0]                  wrdata_i,
    output logic [31:0]                  rdata_o,
    input  logic [NUM_CH*LFSR_WIDTH-1:0] sample_i,
    output logic                         ro_en_o,
    output logic [NUM_CH-1:0]            ch_en_o,
    output logic [NUM_CH*LFSR_WIDTH-1:0] seed_o,
    output logic [NUM_CH*LFSR_WIDTH-1:0] poly_o,
    output logic                         irq_o
);

    localparam int IW = ADDR_WIDTH - 4;

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

    state_t                state;
    logic [IW-1:0]         idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  irq_en;
    logic [NUM_CH-1:0]     ch_en;
    logic                  done;
    logic                  overrun;
    logic [TMW_WIDTH-1:0]  tmw_max;
    logic [TMW_WIDTH-1:0]  tmw_lat;
    logic [TMW_WIDTH-1:0]  cnt;
    logic [LFSR_WIDTH-1:0] seed   [NUM_CH];
    logic [LFSR_WIDTH-1:0] poly   [NUM_CH];
    logic [LFSR_WIDTH-1:0] sample [NUM_CH];

    logic                  busy;
    logic                  ctrl_wr;
    logic                  start;
    logic                  set_done;
    logic                  set_ov;
    logic                  clr_done;
    logic                  clr_ov;
    logic                  done_nxt;
    logic                  ov_nxt;
    logic                  irq_en_nxt;
    logic [31:0]           ctrl_word;
    logic [31:0]           ctrl_merged;
    logic [31:0]           rd_val;

    // Byte-lane merge of write data into a zero-extended register image.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    assign idx       = addr_i[ADDR_WIDTH-1:4];
    assign wr_acc    = en_i & (|we_i);
    assign rd_acc    = en_i & ~(|we_i);
    assign busy      = (state != IDLE);
    assign ctrl_word = 32'({ch_en, 6'b0, irq_en, 1'b0});

    // Decode control-side strobes and next-state values of the sticky flags.
    always_comb begin
        ctrl_wr     = wr_acc && (idx == IW'(1));
        ctrl_merged = merge(ctrl_word, wrdata_i, we_i);
        start       = ctrl_wr && we_i[0] && wrdata_i[0];
        set_done    = (state == CAPTURE);
        set_ov      = start && busy;
        clr_done    = wr_acc && (idx == IW'(2)) && we_i[0] && wrdata_i[1];
        clr_ov      = wr_acc && (idx == IW'(2)) && we_i[0] && wrdata_i[2];
        done_nxt    = (done & ~clr_done) | set_done;
        ov_nxt      = (overrun & ~clr_ov) | set_ov;
        irq_en_nxt  = ctrl_wr ? ctrl_merged[1] : irq_en;
    end

    // CTRL, STATUS flags and the interrupt, which tracks next-state values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en  <= 1'b0;
            ch_en   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (ctrl_wr) ch_en <= ctrl_merged[8 +: NUM_CH];
            irq_en  <= irq_en_nxt;
            done    <= done_nxt;
            overrun <= ov_nxt;
            irq_o   <= irq_en_nxt & (done_nxt | ov_nxt);
        end
    end

    // Software-owned configuration: window length and per-channel seed/poly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmw_max <= TMW_DEFAULT;
            for (int c = 0; c < NUM_CH; c++) begin
                seed[c] <= '0;
                poly[c] <= POLY_DEFAULT;
            end
        end else if (wr_acc) begin
            if (idx == IW'(3)) tmw_max <= TMW_WIDTH'(merge(32'(tmw_max), wrdata_i, we_i));
            for (int c = 0; c < NUM_CH; c++) begin
                if (idx == IW'(16 + 4*c))
                    seed[c] <= LFSR_WIDTH'(merge(32'(seed[c]), wrdata_i, we_i));
                if (idx == IW'(17 + 4*c))
                    poly[c] <= LFSR_WIDTH'(merge(32'(poly[c]), wrdata_i, we_i));
            end
        end
    end

    // Window sequencer: the length is latched at start so mid-run TMW_MAX writes only affect the next run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tmw_lat <= '0;
            ro_en_o <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) sample[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (tmw_max != '0)) begin
                        state   <= RUN;
                        cnt     <= '0;
                        tmw_lat <= tmw_max;
                        ro_en_o <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == tmw_lat - 1'b1) begin
                        state   <= CAPTURE;
                        ro_en_o <= 1'b0;
                    end
                end
                CAPTURE: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (ch_en[c]) sample[c] <= sample_i[c*LFSR_WIDTH +: LFSR_WIDTH];
                    end
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ro_en_o <= 1'b0;
                end
            endcase
        end
    end

    // Read mux; unmapped words and unused upper bits read as zero.
    always_comb begin
        rd_val = '0;
        case (idx)
            IW'(1):  rd_val = ctrl_word;
            IW'(2):  rd_val = {29'b0, overrun, done, busy};
            IW'(3):  rd_val = 32'(tmw_max);
            IW'(4):  rd_val = 32'(cnt);
            default: rd_val = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (idx == IW'(16 + 4*c)) rd_val = 32'(seed[c]);
            if (idx == IW'(17 + 4*c)) rd_val = 32'(poly[c]);
            if (idx == IW'(18 + 4*c)) rd_val = 32'(sample[c]);
        end
    end

    // Registered read data; holds on write and idle cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_o <= '0;
        else if (rd_acc) rdata_o <= rd_val;
    end

    // Flatten per-channel registers onto the channel-facing buses.
    always_comb begin
        seed_o = '0;
        poly_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            seed_o[c*LFSR_WIDTH +: LFSR_WIDTH] = seed[c];
            poly_o[c*LFSR_WIDTH +: LFSR_WIDTH] = poly[c];
        end
    end

    assign ch_en_o = ch_en;

endmodule

// File: tb/tb_trng_csr_bank.sv
module tb_trng_csr_bank;

    localparam int AW = 13;
    localparam int NC = 4;
    localparam int LW = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             en_i;
    logic [3:0]       we_i;
    logic [AW-1:0]    addr_i;
    logic [31:0]      wrdata_i;
    logic [31:0]      rdata_o;
    logic [NC*LW-1:0] sample_i;
    logic             ro_en_o;
    logic [NC-1:0]    ch_en_o;
    logic [NC*LW-1:0] seed_o;
    logic [NC*LW-1:0] poly_o;
    logic             irq_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    typedef struct {
        int          idx;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    trng_csr_bank dut (
        .clk(clk), .rst(rst), .en_i(en_i), .we_i(we_i), .addr_i(addr_i),
        .wrdata_i(wrdata_i), .rdata_o(rdata_o), .sample_i(sample_i),
        .ro_en_o(ro_en_o), .ch_en_o(ch_en_o), .seed_o(seed_o), .poly_o(poly_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus access, driven just after an edge and consumed at the next edge.
    task automatic access(input int idx, input logic [3:0] we, input logic [31:0] d);
        en_i     = 1'b1;
        we_i     = we;
        addr_i   = AW'(idx << 4);
        wrdata_i = d;
        tick();
        en_i     = 1'b0;
        we_i     = 4'b0;
    endtask

    task automatic rd_check(input int idx, input logic [31:0] exp, input string name);
        logic [31:0] e;
        exp_q.push_back(exp);
        access(idx, 4'b0, 32'h0);
        e = exp_q.pop_front();
        check($sformatf("%s idx=0x%0h", name, idx), rdata_o, e);
    endtask

    // Count cycles ro_en_o stays high from now, bounded.
    task automatic count_window(input int already, output int n);
        n = already;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ro_en_o) n++;
            else break;
        end
    endtask

    initial begin
        int n;
        rst = 1'b0; en_i = 1'b0; we_i = 4'b0; addr_i = '0; wrdata_i = '0; sample_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata_o, 32'h0);
        check("reset irq", 32'(irq_o), 32'h0);
        check("reset ro_en", 32'(ro_en_o), 32'h0);
        check("reset poly_o ch0", 32'(poly_o[LW-1:0]), 32'h829);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Reset values of the whole map.
        vecs.push_back('{1, 4'b0, 32'h0, 32'h0});
        vecs.push_back('{2, 4'b0, 32'h0, 32'h0});
        vecs.push_back('{3, 4'b0, 32'h0, 32'd100});
        vecs.push_back('{4, 4'b0, 32'h0, 32'h0});
        for (int c = 0; c < NC; c++) begin
            vecs.push_back('{16 + 4*c, 4'b0, 32'h0, 32'h0});
            vecs.push_back('{17 + 4*c, 4'b0, 32'h0, 32'h829});
            vecs.push_back('{18 + 4*c, 4'b0, 32'h0, 32'h0});
        end
        vecs.push_back('{16 + 4*NC, 4'b0, 32'h0, 32'h0});
        // Byte-lane writes and truncation.
        vecs.push_back('{20, 4'b0001, 32'h0000_ABCD, 32'h0});
        vecs.push_back('{20, 4'b0000, 32'h0, 32'h0CD});
        vecs.push_back('{20, 4'b0010, 32'h0000_FFFF, 32'h0});
        vecs.push_back('{20, 4'b0000, 32'h0, 32'hFCD});
        vecs.push_back('{25, 4'b1111, 32'h1234_5678, 32'h0});
        vecs.push_back('{25, 4'b0000, 32'h0, 32'h678});
        vecs.push_back('{16, 4'b1111, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{16, 4'b0000, 32'h0, 32'hFFF});
        vecs.push_back('{3, 4'b0010, 32'h0000_0700, 32'h0});
        vecs.push_back('{3, 4'b0000, 32'h0, 32'h764});
        // Out-of-range channel: write ignored, reads zero, neighbours intact.
        vecs.push_back('{16 + 4*NC, 4'b1111, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{16 + 4*NC, 4'b0000, 32'h0, 32'h0});
        vecs.push_back('{20, 4'b0000, 32'h0, 32'hFCD});
        // CTRL field packing; START bit never reads back.
        vecs.push_back('{1, 4'b1111, 32'hFFFF_FFFE, 32'h0});
        vecs.push_back('{1, 4'b0000, 32'h0, 32'hF02});

        foreach (vecs[i]) begin
            if (vecs[i].we != 4'b0) access(vecs[i].idx, vecs[i].we, vecs[i].wd);
            else rd_check(vecs[i].idx, vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("seed_o ch1", 32'(seed_o[23:12]), 32'hFCD);
        check("ch_en_o", 32'(ch_en_o), 32'hF);

        // Window: 5 cycles, channels 0 and 2 captured, interrupt then W1C.
        sample_i = {12'h444, 12'h333, 12'h222, 12'h111};
        access(3, 4'b1111, 32'd5);
        access(1, 4'b1111, 32'h0000_0502);
        access(1, 4'b1111, 32'h0000_0503);
        check("window ro_en start", 32'(ro_en_o), 32'h1);
        count_window(1, n);
        check("window length", n, 5);
        tick();
        check("irq after done", 32'(irq_o), 32'h1);
        rd_check(18, 32'h111, "sample ch0");
        rd_check(22, 32'h0,   "sample ch1");
        rd_check(26, 32'h333, "sample ch2");
        rd_check(30, 32'h0,   "sample ch3");
        rd_check(2, 32'h2, "status done");
        access(2, 4'b1111, 32'h2);
        check("irq after w1c", 32'(irq_o), 32'h0);
        rd_check(2, 32'h0, "status cleared");

        // Overrun: a second START mid-window flags but does not restart.
        access(1, 4'b1111, 32'h0000_0503);
        access(1, 4'b1111, 32'h0000_0503);
        check("overrun ro_en", 32'(ro_en_o), 32'h1);
        count_window(2, n);
        check("overrun window length", n, 5);
        tick();
        rd_check(2, 32'h6, "status overrun");
        access(2, 4'b1111, 32'h6);

        // DONE set in the same cycle as its W1C: set wins.
        access(1, 4'b1111, 32'h0000_0503);
        rd_check(2, 32'h1, "status busy");
        count_window(2, n);
        check("w1c window length", n, 5);
        access(2, 4'b1111, 32'h2);
        rd_check(2, 32'h2, "status set wins");
        access(2, 4'b1111, 32'h6);

        // TMW_MAX=0: START ignored.
        access(3, 4'b1111, 32'h0);
        access(1, 4'b1111, 32'h0000_0503);
        check("zero tmw ro_en", 32'(ro_en_o), 32'h0);
        tick();
        rd_check(2, 32'h0, "zero tmw status");
        check("zero tmw irq", 32'(irq_o), 32'h0);

        // Abort: reset during cycle 2 of a 10-cycle window.
        sample_i = {12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD};
        access(3, 4'b1111, 32'd10);
        access(1, 4'b1111, 32'h0000_0F03);
        tick();
        check("abort ro_en before", 32'(ro_en_o), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("abort ro_en async", 32'(ro_en_o), 32'h0);
        #2 rst = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (ro_en_o) n++;
        end
        check("abort stays idle", n, 0);
        rd_check(18, 32'h0, "abort sample ch0");
        rd_check(26, 32'h0, "abort sample ch2");
        rd_check(2, 32'h0, "abort status");
        rd_check(3, 32'd100, "abort tmw_max");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
